// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and helpers for the SRAM access controller and its arbiter.
package sram_access_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
  typedef enum logic {PIPE, LOADER} ownerT;

  localparam int MEM_BASE_DEF = 1024;
  localparam int WAIT_MIN     = 1;
  localparam int WAIT_MAX     = 15;
  localparam int CNT_W        = 4;

  // Word-aligned and inside [base, base + 4*2^aw); computed wide to avoid wrap.
  function automatic logic addrOk(input logic [31:0] addr, input logic [31:0] base,
                                  input int aw);
    logic [33:0] lim;
    lim = {2'b00, base} + (34'd1 << (aw + 2));
    return (addr[1:0] == 2'b00) && (addr >= base) && ({2'b00, addr} < lim);
  endfunction

endpackage

// File: rtl/sram_access_ctrl_arbiter.sv
// Two-way round-robin arbiter; a tie goes to whichever side was not served last.
module mem_req_arbiter
  import sram_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pipe_req,
  input  logic ld_req,
  input  logic arb_en,
  output logic grant_pipe,
  output logic grant_ld
);

  ownerT lastOwner;

  always_comb begin
    grant_pipe = 1'b0;
    grant_ld   = 1'b0;
    if (arb_en) begin
      if (pipe_req && ld_req) begin
        grant_pipe = (lastOwner == LOADER);
        grant_ld   = (lastOwner == PIPE);
      end else begin
        grant_pipe = pipe_req;
        grant_ld   = ld_req;
      end
    end
  end

  // Only one grant per access, so recording at grant time equals recording at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           lastOwner <= LOADER;
    else if (grant_pipe) lastOwner <= PIPE;
    else if (grant_ld)   lastOwner <= LOADER;
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Multi-cycle SRAM controller shared between the MEM stage and a loader port;
// stalls the pipeline with freeze until its own access completes.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 4,
  parameter int MEM_BASE    = MEM_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memREn,
  input  logic              memWEn,
  input  logic [31:0]       aluRes,
  input  logic [31:0]       valRm,
  output logic              freeze,
  output logic [31:0]       pipe_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_done,
  output logic [31:0]       ld_rdata,
  output logic              addr_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  stateT             state, stateNext;
  ownerT             owner;
  logic              opWr, opErr;
  logic [31:0]       opAddr, opData;
  logic [CNT_W-1:0]  cnt;

  logic              pipeReq, grantPipe, grantLd, grant;
  logic              selWr, selOk;
  logic [31:0]       selAddr, selData;
  logic              inAccess, isDone, pipeDone;

  assign pipeReq = memREn | memWEn;
  assign grant   = grantPipe | grantLd;

  mem_req_arbiter uArb (
    .clk        (clk),
    .rst        (rst),
    .pipe_req   (pipeReq),
    .ld_req     (ld_req),
    .arb_en     (state == IDLE),
    .grant_pipe (grantPipe),
    .grant_ld   (grantLd)
  );

  // Write wins over read when the pipeline raises both.
  assign selWr   = grantPipe ? memWEn : ld_we;
  assign selAddr = grantPipe ? aluRes : ld_addr;
  assign selData = grantPipe ? valRm  : ld_wdata;
  assign selOk   = addrOk(selAddr, 32'(MEM_BASE), ADDR_W);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grant) stateNext = selOk ? ACCESS : DONE;
      ACCESS:  if (cnt == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= LOADER;
      opWr       <= 1'b0;
      opErr      <= 1'b0;
      opAddr     <= '0;
      opData     <= '0;
      cnt        <= '0;
      pipe_rdata <= '0;
      ld_rdata   <= '0;
    end else begin
      state <= stateNext;
      if (grant) begin
        owner  <= grantPipe ? PIPE : LOADER;
        opWr   <= selWr;
        opErr  <= ~selOk;
        opAddr <= selAddr;
        opData <= selData;
        cnt    <= CNT_W'(WAIT_CYCLES - 1);
        // Out-of-range reads complete next cycle with zero data.
        if (!selOk && !selWr) begin
          if (grantPipe) pipe_rdata <= '0;
          else           ld_rdata   <= '0;
        end
      end else if (state == ACCESS) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else if (!opWr) begin
          if (owner == PIPE) pipe_rdata <= sram_rdata;
          else               ld_rdata   <= sram_rdata;
        end
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign inAccess   = (state == ACCESS);
  assign isDone     = (state == DONE);
  assign sram_ce_n  = ~inAccess;
  assign sram_oe_n  = ~(inAccess & ~opWr);
  assign sram_dq_oe = inAccess & opWr;
  assign sram_we_n  = ~(inAccess & opWr & (cnt != '0));
  assign sram_addr  = inAccess ? ADDR_W'((opAddr - 32'(MEM_BASE)) >> 2) : '0;
  assign sram_wdata = opData;

  assign pipeDone = isDone & (owner == PIPE);
  assign ld_done  = isDone & (owner == LOADER);
  assign addr_err = isDone & opErr;
  assign freeze   = pipeReq & ~pipeDone;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench with a transaction-level reference model checked every cycle.
module tb_sram_access_ctrl;
  localparam int AW = 16, WC = 4, BASE = 1024;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic memREn = 0, memWEn = 0, ld_req = 0, ld_we = 0;
  logic [31:0] aluRes = 0, valRm = 0, ld_addr = 0, ld_wdata = 0;
  logic freeze, ld_done, addr_err, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;
  logic [31:0] pipe_rdata, ld_rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;

  sram_access_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC), .MEM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .memREn(memREn), .memWEn(memWEn), .aluRes(aluRes),
    .valRm(valRm), .freeze(freeze), .pipe_rdata(pipe_rdata), .ld_req(ld_req),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
    .ld_rdata(ld_rdata), .addr_err(addr_err), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // External SRAM
  logic [31:0] sramMem [0:255];
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sramMem[sram_addr[7:0]] : 32'h0;
  initial begin
    for (int i = 0; i < 256; i++) sramMem[i] = 32'h0;
    sramMem[1] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (!sram_ce_n && !sram_we_n) sramMem[sram_addr[7:0]] <= sram_wdata;
    end
  end

  // Reference model: an access is (grant, len strobe cycles, one done cycle).
  logic [31:0] refMem [0:255];
  int mAge, mLen, mOwn, mLast, mIdx;
  bit mWr, mErr;
  logic [31:0] mData, mWord, expPR, expLR;

  initial begin
    bit pReq, acc, dn;
    logic [31:0] a, v;
    longint la;
    for (int i = 0; i < 256; i++) refMem[i] = 32'h0;
    refMem[1] = 32'hDEADBEEF;
    mAge = -1; mLast = 1; expPR = 0; expLR = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mAge = -1; mLast = 1; expPR = 0; expLR = 0;
        continue;
      end
      pReq = memREn | memWEn;
      acc  = (mAge >= 1) && (mAge <= mLen);
      dn   = (mAge >= 0) && (mAge == mLen + 1);
      chk("freeze", 32'(freeze), 32'(pReq && !(dn && mOwn == 0)));
      chk("ld_done", 32'(ld_done), 32'(dn && mOwn == 1));
      chk("addr_err", 32'(addr_err), 32'(dn && mErr));
      chk("ce_n", 32'(sram_ce_n), 32'(!acc));
      chk("oe_n", 32'(sram_oe_n), 32'(!(acc && !mWr)));
      chk("we_n", 32'(sram_we_n), 32'(!(acc && mWr && mAge < mLen)));
      chk("dq_oe", 32'(sram_dq_oe), 32'(acc && mWr));
      if (acc) chk("sram_addr", 32'(sram_addr), mWord);
      if (acc && mWr) chk("sram_wdata", sram_wdata, mData);
      chk("pipe_rdata", pipe_rdata, expPR);
      chk("ld_rdata", ld_rdata, expLR);
      // advance one cycle
      if (dn) mAge = -1;
      else if (mAge >= 1) mAge++;
      else if (pReq || ld_req) begin
        mOwn = (pReq && ld_req) ? (mLast == 0 ? 1 : 0) : (pReq ? 0 : 1);
        mLast = mOwn;
        a     = mOwn == 0 ? aluRes : ld_addr;
        mWr   = mOwn == 0 ? memWEn : ld_we;
        mData = mOwn == 0 ? valRm  : ld_wdata;
        la    = longint'(a);
        mErr  = (la < BASE) || (la >= BASE + 4 * (longint'(1) << AW)) || (la % 4 != 0);
        mWord = ((a - BASE) / 4) % (1 << AW);
        mIdx  = int'(mWord % 256);
        mLen  = mErr ? 0 : WC;
        mAge  = 1;
      end
      if (mAge >= 1 && mAge == mLen + 1) begin
        if (!mWr) begin
          v = mErr ? 32'h0 : refMem[mIdx];
          if (mOwn == 0) expPR = v; else expLR = v;
        end else if (!mErr) refMem[mIdx] = mData;
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
  endtask

  // Pipeline access alone; counts freeze/strobe cycles from the request cycle.
  task automatic pipeOp(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int frz, output int oeC, output int weC, output int dqC,
                        output int aeC, output logic [31:0] sa);
    bit fin;
    frz = 0; oeC = 0; weC = 0; dqC = 0; aeC = 0; sa = 32'hFFFF_FFFF; fin = 0;
    memREn = !wr; memWEn = wr; aluRes = a; valRm = d;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      if (!sram_oe_n) oeC++;
      if (!sram_we_n) weC++;
      if (sram_dq_oe) dqC++;
      if (!sram_ce_n) sa = 32'(sram_addr);
      if (addr_err) aeC++;
      if (freeze) frz++; else fin = 1;
    end
    if (!fin) chk("pipe_timeout", 0, 1);
    @(posedge clk); #1 memREn = 0; memWEn = 0;
  endtask

  // Runs until both the pipeline and loader complete; cycle 0 is the cycle
  // in which the inputs were last changed by the caller.
  task automatic runBoth(output int frzLow, output int ldDn);
    frzLow = -1; ldDn = -1;
    for (int c = 0; c < 80 && (frzLow < 0 || ldDn < 0); c++) begin
      @(negedge clk);
      if (frzLow < 0 && !freeze) frzLow = c;
      if (ldDn < 0 && ld_done) ldDn = c;
      @(posedge clk); #1;
      if (frzLow == c) begin memREn = 0; memWEn = 0; end
      if (ldDn == c) ld_req = 0;
    end
    if (frzLow < 0 || ldDn < 0) chk("both_timeout", 0, 1);
  endtask

  task automatic tieTest();
    int fl, ld;
    memREn = 1; aluRes = 1028; ld_req = 1; ld_we = 0; ld_addr = 1032;
    runBoth(fl, ld);
    chk("tie_freeze_low_cycle", 32'(fl), 5);
    chk("tie_loader_after_pipe", 32'(ld > fl), 1);
    chk("tie_pipe_rdata", pipe_rdata, 32'hDEADBEEF);
    chk("tie_ld_rdata", ld_rdata, 32'h12345678);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int frz, oeC, weC, dqC, aeC, fl, ld;
    logic [31:0] sa;
    repeat (3) @(posedge clk);
    // reset state
    @(negedge clk);
    chk("rst_ce_n", 32'(sram_ce_n), 1);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_oe_n", 32'(sram_oe_n), 1);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_sram_addr", 32'(sram_addr), 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;

    // 1: pipeline read of word 1
    pipeOp(0, 1028, 0, frz, oeC, weC, dqC, aeC, sa);
    chk("t1_freeze_cycles", 32'(frz), 5);
    chk("t1_oe_cycles", 32'(oeC), 4);
    chk("t1_sram_addr", sa, 1);
    chk("t1_rdata", pipe_rdata, 32'hDEADBEEF);

    // 2: pipeline write to word 2, then read back
    pipeOp(1, 1032, 32'h12345678, frz, oeC, weC, dqC, aeC, sa);
    chk("t2_we_cycles", 32'(weC), 3);
    chk("t2_dq_cycles", 32'(dqC), 4);
    chk("t2_sram_addr", sa, 2);
    chk("t2_sram_word", sramMem[2], 32'h12345678);
    pipeOp(0, 1032, 0, frz, oeC, weC, dqC, aeC, sa);
    chk("t2_readback", pipe_rdata, 32'h12345678);

    // 3: simultaneous requests after reset
    doReset();
    tieTest();

    // 4: pipeline write arrives while loader owns the SRAM
    ld_req = 1; ld_we = 0; ld_addr = 1028;
    repeat (2) @(posedge clk);
    #1 memWEn = 1; aluRes = 1036; valRm = 32'hA5A50F0F;
    runBoth(fl, ld);
    chk("t4_freeze_after_ld", 32'(fl - ld), 6);
    chk("t4_ld_rdata", ld_rdata, 32'hDEADBEEF);
    chk("t4_sram_word", sramMem[3], 32'hA5A50F0F);
    pipeOp(0, 1036, 0, frz, oeC, weC, dqC, aeC, sa);
    chk("t4_readback", pipe_rdata, 32'hA5A50F0F);

    // 5: out-of-range addresses
    pipeOp(0, 1000, 0, frz, oeC, weC, dqC, aeC, sa);
    chk("t5a_freeze_cycles", 32'(frz), 1);
    chk("t5a_no_strobe", 32'(oeC), 0);
    chk("t5a_addr_err", 32'(aeC), 1);
    chk("t5a_rdata", pipe_rdata, 0);
    pipeOp(0, 1028, 0, frz, oeC, weC, dqC, aeC, sa);
    pipeOp(0, 1030, 0, frz, oeC, weC, dqC, aeC, sa);
    chk("t5b_freeze_cycles", 32'(frz), 1);
    chk("t5b_no_strobe", 32'(oeC), 0);
    chk("t5b_addr_err", 32'(aeC), 1);
    chk("t5b_rdata", pipe_rdata, 0);
    pipeOp(1, 1000, 32'h55555555, frz, oeC, weC, dqC, aeC, sa);
    chk("t5c_no_we", 32'(weC + dqC), 0);
    chk("t5c_addr_err", 32'(aeC), 1);

    // 6: reset during a loader write
    ld_req = 1; ld_we = 1; ld_addr = 1044; ld_wdata = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1 rst = 0; ld_req = 0;
    #1;
    chk("t6_ce_n", 32'(sram_ce_n), 1);
    chk("t6_we_n", 32'(sram_we_n), 1);
    chk("t6_dq_oe", 32'(sram_dq_oe), 0);
    chk("t6_ld_done", 32'(ld_done), 0);
    chk("t6_addr_err", 32'(addr_err), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    tieTest();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
